dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data memory port between two requesters: the core load/store path (port 0) and a program/debug loader (port 1). It sits between the requesters and the data memory, serialising one transaction at a time. It drives the memory chip-select, read/write enables, address, write data and byte mask from registered values. It also returns read data with a valid pulse. Arbitration is round-robin.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; the mask is DW/8 bits
- RD_LAT, 1, memory read latency in cycles from the strobe cycle to valid `mem_rdata`; legal range 1..7

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- req  in  2  per-port request; bit 0 = core, bit 1 = loader
- we  in  2  per-port write enable; 1 = store, 0 = load
- addr0, addr1  in  AW each  per-port byte address
- wdata0, wdata1  in  DW each  per-port store data
- mask0, mask1  in  DW/8 each  per-port byte mask
- gnt  out  2  one-cycle pulse: command of that port accepted
- rvalid  out  2  one-cycle pulse: read data for that port on `rdata`
- rdata  out  DW  captured read data, shared by both ports
- busy  out  1  high while not in IDLE
- mem_cs, mem_rd_en, mem_wr_en  out  1 each  memory strobes
- mem_addr  out  AW  address to memory
- mem_wdata  out  DW  store data to memory
- mem_mask  out  DW/8  byte mask to memory
- mem_rdata  in  DW  read data from memory

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any `req` bit is high at the edge:
  - pick the winner, capture its `we`, address, data and mask into command registers, and store the winner index;
  - next state is ISSUE.
- Arbitration: `last` holds the most recently granted port and resets to 1.
  - Both ports requesting: the port not equal to `last` wins.
  - One port requesting: that port wins.
  - `last` updates when the command is captured.
- ISSUE lasts exactly one cycle:
  - `mem_cs` = 1; `mem_wr_en` = captured `we`; `mem_rd_en` = ~captured `we`;
  - `mem_addr`, `mem_wdata` and `mem_mask` come from the command registers;
  - `gnt[winner]` = 1.
  - Write: next state is IDLE. Read: load the latency counter with RD_LAT-1, next state is WAIT.
- WAIT:
  - all strobes are 0;
  - the counter decrements each cycle; when it reads 0, capture `mem_rdata` into `rdata`, pulse `rvalid[winner]`, and go to IDLE.
- `rdata` holds its value until the next read capture.
- Requesters must hold `req` and the command fields stable until `gnt`. Deasserting `req` after capture does not cancel the committed transaction.
- `mem_addr`, `mem_wdata` and `mem_mask` hold their last values outside ISSUE. Only the strobes are qualified.

## Timing
- Reset values: state IDLE, `last` = 1, counter 0; `gnt`, `rvalid`, `busy`, `mem_cs`, `mem_rd_en` and `mem_wr_en` all 0; `rdata`, `mem_addr`, `mem_wdata` and `mem_mask` all 0.
- Cycle numbering: `req` is sampled at edge E0.
- Write:
  - ISSUE and `gnt` occur in cycle 1;
  - IDLE again in cycle 2;
  - a new request seen at the edge ending cycle 2 gets ISSUE in cycle 3.
  - Back-to-back write throughput is one transaction per 2 cycles.
- Read:
  - ISSUE and `gnt` in cycle 1;
  - WAIT in cycles 2..RD_LAT+1;
  - `rvalid` and valid `rdata` visible in cycle RD_LAT+2 (with RD_LAT=1, in cycle 3);
  - IDLE in cycle RD_LAT+2.
- Requests arriving while busy are ignored until the FSM is in IDLE. No queuing beyond the held `req`.
- Synchronous reset in any state, including mid-WAIT, aborts the transaction on the next edge. No `rvalid` is produced and all outputs return to reset values.
- `gnt` and `rvalid` are never both high in the same cycle. At most one bit of each is high.

## Test plan
- Single core write: `req` = 01, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF, mask0 = 0xF → one-cycle ISSUE with `mem_wr_en` = 1, `mem_addr` = 0x10, `gnt` = 01; `rvalid` never asserts.
- Single loader read, RD_LAT = 1: `req` = 10, addr1 = 0x20, memory returns 0x12345678 → `gnt` = 10 in cycle 1; `rvalid` = 10 and `rdata` = 0x12345678 in cycle 3.
- Contention: both ports hold `req` with reads after reset → grant order is port 0, port 1, port 0, port 1. No port is granted twice in a row.
- RD_LAT = 3: read request → WAIT lasts 3 cycles; `rvalid` is in cycle 5; strobes are high only in cycle 1.
- Reset mid-WAIT (RD_LAT = 3, reset asserted in cycle 3) → no `rvalid`, `busy` = 0 after that edge. The next request after reset goes to port 0 on a tie.
- `req` dropped after capture: `req` = 01 for one cycle only → ISSUE and `gnt` still occur once; the FSM then idles with `busy` = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core (port 0)
// and the loader (port 1); one transaction in flight, strobes qualified by FSM state.
module dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata0,
  input  logic [DW-1:0]   wdata1,
  input  logic [DW/8-1:0] mask0,
  input  logic [DW/8-1:0] mask1,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic            mem_cs,
  output logic            mem_rd_en,
  output logic            mem_wr_en,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_mask,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int MW = DW / 8;
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_next;
  logic            last;
  logic            win;
  logic            capture;
  logic            rd_done;
  logic            cmd_port;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [MW-1:0]   cmd_mask;
  logic [2:0]      cnt;

  // On a tie the port that was not granted most recently wins.
  assign win     = (req == 2'b11) ? ~last : req[1];
  assign capture = (state == IDLE) && (req != 2'b00);
  assign rd_done = (state == WAIT) && (cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    gnt        = 2'b00;
    mem_cs     = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != 2'b00) state_next = ISSUE;
      end
      ISSUE: begin
        mem_cs        = 1'b1;
        mem_wr_en     = cmd_we;
        mem_rd_en     = ~cmd_we;
        gnt[cmd_port] = 1'b1;
        state_next    = cmd_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt == 3'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 1'b1;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_mask  <= '0;
      cnt       <= 3'd0;
      rdata     <= '0;
      rvalid    <= 2'b00;
    end else begin
      rvalid <= 2'b00;
      if (capture) begin
        last      <= win;
        cmd_port  <= win;
        cmd_we    <= we[win];
        cmd_addr  <= win ? addr1  : addr0;
        cmd_wdata <= win ? wdata1 : wdata0;
        cmd_mask  <= win ? mask1  : mask0;
      end
      // The counter reaching zero marks the cycle mem_rdata is valid.
      if (state == ISSUE && !cmd_we)       cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 0)  cnt <= cnt - 3'd1;
      if (rd_done) begin
        rdata            <= mem_rdata;
        rvalid[cmd_port] <= 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign mem_mask  = cmd_mask;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two requester drivers, a behavioural memory, and a
// transaction-level reference model checked by a negedge monitor.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MW     = DW / 8;
  localparam int RD_LAT = 3;
  localparam int W      = DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  // ---------------- main DUT (RD_LAT = 3) ----------------
  logic          req0_r = 1'b0, req1_r = 1'b0, we0_r = 1'b0, we1_r = 1'b0;
  logic [1:0]    req, we;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [MW-1:0] mask0 = '0, mask1 = '0;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          busy, mem_cs, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_mask;

  assign req = {req1_r, req0_r};
  assign we  = {we1_r, we0_r};

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .mask0(mask0), .mask1(mask1), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .busy(busy), .mem_cs(mem_cs), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata)
  );

  // ---------------- second DUT (RD_LAT = 1), directed only ----------------
  logic          l1_reset = 1'b1;
  logic [1:0]    l1_req = 2'b00;
  logic [1:0]    l1_gnt, l1_rvalid;
  logic [DW-1:0] l1_rdata, l1_mem_wdata;
  logic [DW-1:0] l1_mem_rdata = '0;
  logic          l1_busy, l1_mem_cs, l1_mem_rd_en, l1_mem_wr_en;
  logic [AW-1:0] l1_mem_addr;
  logic [MW-1:0] l1_mem_mask;
  logic          l1_done = 1'b0;

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(l1_reset), .req(l1_req), .we(2'b00),
    .addr0(32'h0), .addr1(32'h20), .wdata0(32'h0), .wdata1(32'h0),
    .mask0(4'h0), .mask1(4'h0), .gnt(l1_gnt), .rvalid(l1_rvalid), .rdata(l1_rdata),
    .busy(l1_busy), .mem_cs(l1_mem_cs), .mem_rd_en(l1_mem_rd_en), .mem_wr_en(l1_mem_wr_en),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_mask(l1_mem_mask),
    .mem_rdata(l1_mem_rdata)
  );

  always @(posedge clk)
    l1_mem_rdata <= (l1_mem_cs && l1_mem_rd_en) ? 32'h12345678 : 32'hA5A5A5A5;

  // ---------------- counters and check helper ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [DW-1:0] env_mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW:0]   rd_pipe [RD_LAT];
  logic [DW-1:0] junk = '0;

  always @(posedge clk) begin
    junk <= $urandom;
    if (mem_cs && mem_wr_en)
      for (int b = 0; b < MW; b++)
        if (mem_mask[b]) env_mem[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= (mem_cs && mem_rd_en) ? {1'b1, env_mem[mem_addr[5:2]]} : '0;
  end

  // Data is only valid in the single cycle RD_LAT after the strobe.
  assign mem_rdata = rd_pipe[RD_LAT-1][DW] ? rd_pipe[RD_LAT-1][DW-1:0] : junk;

  // ---------------- reference model + monitor ----------------
  logic [W-1:0]  exp_q [$];
  int            gnt_log [$];
  int            gnt_cnt [2] = '{0, 0};
  int            cyc = 0;
  int            rd_due = 0;
  logic          pend = 1'b0, rd_out = 1'b0, last_m = 1'b1, rst_prev = 1'b0;
  logic [1:0]    prev_req = 2'b00;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0, last_rdata = '0;
  logic [MW-1:0] last_mask = '0;

  always @(negedge clk) begin
    logic [W-1:0]  e;
    int            p;
    logic          pwe, idle_now;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [MW-1:0] pm;
    cyc++;
    if (rst_prev) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {mem_cs, mem_rd_en, mem_wr_en}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_mask", mem_mask, 0);
    end
    chk("gnt_rvalid_excl", (gnt != 2'b00) && (rvalid != 2'b00), 0);

    if (rd_out && cyc == rd_due) begin
      e = exp_q.pop_front();
      chk("rvalid_port", rvalid, e[DW] ? 2'b10 : 2'b01);
      chk("rdata", rdata, e[DW-1:0]);
      last_rdata = e[DW-1:0];
      rd_out = 1'b0;
    end else begin
      chk("rvalid_quiet", rvalid, 0);
      chk("rdata_hold", rdata, last_rdata);
    end

    chk("gnt_timing", gnt != 2'b00, pend);
    if (gnt == 2'b01) begin gnt_cnt[0]++; gnt_log.push_back(0); end
    if (gnt == 2'b10) begin gnt_cnt[1]++; gnt_log.push_back(1); end

    if (pend) begin
      p   = (prev_req == 2'b11) ? (last_m ? 0 : 1) : (prev_req[1] ? 1 : 0);
      pwe = (p == 1) ? we1_r  : we0_r;
      pa  = (p == 1) ? addr1  : addr0;
      pd  = (p == 1) ? wdata1 : wdata0;
      pm  = (p == 1) ? mask1  : mask0;
      chk("gnt_port", gnt, (p == 1) ? 2'b10 : 2'b01);
      chk("issue_cs", mem_cs, 1);
      chk("issue_wr_en", mem_wr_en, pwe);
      chk("issue_rd_en", mem_rd_en, !pwe);
      last_m = (p == 1);
      last_addr = pa; last_wdata = pd; last_mask = pm;
      if (pwe) begin
        for (int b = 0; b < MW; b++)
          if (pm[b]) ref_mem[pa[5:2]][b*8 +: 8] = pd[b*8 +: 8];
      end else begin
        exp_q.push_back({(p == 1), ref_mem[pa[5:2]]});
        rd_out = 1'b1;
        rd_due = cyc + RD_LAT + 1;
      end
    end else begin
      chk("strobes_quiet", {mem_cs, mem_rd_en, mem_wr_en}, 0);
    end
    chk("mem_addr", mem_addr, last_addr);
    chk("mem_wdata", mem_wdata, last_wdata);
    chk("mem_mask", mem_mask, last_mask);

    idle_now = !pend && !rd_out;
    chk("busy", busy, !idle_now);
    pend     = idle_now && (req != 2'b00);
    prev_req = req;
    rst_prev = reset;
    if (reset) begin
      pend = 1'b0; rd_out = 1'b0; last_m = 1'b1;
      exp_q.delete();
      last_addr = '0; last_wdata = '0; last_mask = '0; last_rdata = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    if (p == 0) begin req0_r = r; we0_r = w; addr0 = a; wdata0 = d; mask0 = m; end
    else        begin req1_r = r; we1_r = w; addr1 = a; wdata1 = d; mask1 = m; end
  endtask

  // Holds the request until its grant is seen, then drops req.
  task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
    int start, n;
    start = gnt_cnt[p];
    set_cmd(p, 1'b1, w, a, d, m);
    n = 0;
    while (gnt_cnt[p] == start && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("grant_seen", gnt_cnt[p] != start, 1);
    if (p == 0) req0_r = 1'b0; else req1_r = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      a = '0;
      a[5:2] = 4'($urandom_range(0, 15));
      issue(p, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- RD_LAT = 1 directed read ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1 l1_reset = 1'b0;
    @(posedge clk); #1 l1_req = 2'b10;
    @(posedge clk); #1 l1_req = 2'b00;
    chk("l1_gnt_c1", l1_gnt, 2'b10);
    chk("l1_rd_en_c1", {l1_mem_cs, l1_mem_rd_en, l1_mem_wr_en}, 3'b110);
    chk("l1_addr_c1", l1_mem_addr, 32'h20);
    @(posedge clk); #1;
    chk("l1_rvalid_c2", l1_rvalid, 2'b00);
    chk("l1_busy_c2", l1_busy, 1);
    @(posedge clk); #1;
    chk("l1_rvalid_c3", l1_rvalid, 2'b10);
    chk("l1_rdata_c3", l1_rdata, 32'h12345678);
    chk("l1_busy_c3", l1_busy, 0);
    @(posedge clk); #1;
    chk("l1_rvalid_c4", l1_rvalid, 2'b00);
    chk("l1_rdata_hold", l1_rdata, 32'h12345678);
    l1_done = 1'b1;
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int start, n;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
    end
    for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycles(2);

    // Contention: both ports keep reading.
    gnt_log.delete();
    fork
      begin issue(0, 1'b0, 32'h04, 32'h0, 4'h0); issue(0, 1'b0, 32'h08, 32'h0, 4'h0); end
      begin issue(1, 1'b0, 32'h0C, 32'h0, 4'h0); issue(1, 1'b0, 32'h14, 32'h0, 4'h0); end
    join
    chk("rr_log_size", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("rr_order", gnt_log[i], i % 2);
    idle_cycles(RD_LAT + 3);

    // Single core write, then read it back through the loader.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0);
    idle_cycles(RD_LAT + 3);

    // Reset in the middle of WAIT.
    issue(1, 1'b0, 32'h24, 32'h0, 4'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rvalid", rvalid, 0);
    idle_cycles(3);
    gnt_log.delete();
    fork
      issue(0, 1'b0, 32'h28, 32'h0, 4'h0);
      issue(1, 1'b0, 32'h2C, 32'h0, 4'h0);
    join
    chk("tie_log_size", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("tie_after_reset", gnt_log[0], 0);
    idle_cycles(RD_LAT + 3);

    // Request held for one cycle only.
    start = gnt_cnt[0];
    set_cmd(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'h3);
    @(posedge clk); #1 req0_r = 1'b0;
    idle_cycles(4);
    chk("drop_gnt_once", gnt_cnt[0] - start, 1);
    chk("drop_idle", busy, 0);

    // Randomized traffic on both ports.
    fork
      rand_port(0, 60);
      rand_port(1, 60);
    join
    idle_cycles(RD_LAT + 4);
    chk("scoreboard_drained", exp_q.size(), 0);

    n = 0;
    while (!l1_done && n < 100) begin @(posedge clk); n++; end
    chk("lat1_done", l1_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
